branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
Sequencing controller for the D-stage branch comparator. Holds a decoded branch in D until its operands are forwarded and ready, then drives the comparator's branch type and samples its result. Registers the taken/not-taken decision and issues a one-cycle PC redirect to the F-stage NPC logic. Keeps saturating branch and taken-branch statistics and a stall watchdog.

Parameters:
MAX_WAIT, 16, stall cycles allowed in WAIT before timeout (1..255)
CNT_W, 32, width of statistics counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
d_valid  in  1  D stage holds a valid instruction
d_btype  in  3  decoded branch type; 3'b000 = not a branch, 001..111 = comparator encodings
d_target  in  32  branch target computed in D
ops_ready  in  1  rs/rt forwarded values valid this cycle (from hazard unit)
d_flush  in  1  abort current D instruction (exception/eret)
cmp_result  in  1  comparator output for cmp_btype this cycle
cmp_btype  out  3  branch type driven to comparator
stall_d  out  1  freeze F/D, bubble into E
redirect_valid  out  1  one-cycle PC redirect strobe
redirect_pc  out  32  redirect target
busy  out  1  state != IDLE
err_timeout  out  1  sticky watchdog flag
br_cnt  out  CNT_W  resolved branches, saturating
taken_cnt  out  CNT_W  taken branches, saturating

Behaviour:
- Reset (async, on reset high): state=IDLE, taken_q=0, target_q=0, wait_cnt=0, err_timeout=0, br_cnt=0, taken_cnt=0. All outputs 0.
- is_br = d_valid & (d_btype != 0). cmp_btype = d_btype when is_br, else 3'b000; combinational in all states.
- States: IDLE, WAIT, RESOLVED.
- IDLE:
  - is_br & !d_flush & ops_ready: latch taken_q=cmp_result, target_q=d_target; increment br_cnt, plus taken_cnt if cmp_result; -> RESOLVED; stall_d=0.
  - is_br & !d_flush & !ops_ready: stall_d=1; wait_cnt=1; -> WAIT.
  - Otherwise: stay; stall_d=0.
- WAIT:
  - d_flush: -> IDLE, wait_cnt=0, no redirect, counters unchanged; stall_d=0.
  - ops_ready: latch as in IDLE; -> RESOLVED; stall_d=0 this cycle; wait_cnt=0.
  - !ops_ready & wait_cnt==MAX_WAIT: set err_timeout; branch dropped as not-taken (no counter update); -> IDLE; stall_d=0.
  - Else: stall_d=1; wait_cnt+1.
  - Timeout check precedes the increment; d_flush has priority over ops_ready and timeout.
- RESOLVED (exactly one cycle):
  - redirect_valid=taken_q, redirect_pc=taken_q ? target_q : 0.
  - d_flush: redirect_valid=0 (suppress); -> IDLE.
  - is_br (branch in delay slot): stall_d=1 for this cycle; it is re-evaluated in IDLE next cycle.
  - -> IDLE.
- Latency: operands ready at branch arrival -> redirect_valid exactly 1 cycle later. Each WAIT cycle adds 1.
- redirect_valid is never high on two consecutive cycles.
- Counters saturate at all-ones; no wrap.
- busy = (state != IDLE).
- err_timeout clears only on reset.

Test Plan:
- BEQ ready: d_btype=001, ops_ready=1, cmp_result=1, d_target=0x0000_3010 -> next cycle redirect_valid=1, redirect_pc=0x3010, br_cnt=1, taken_cnt=1, stall_d never 1.
- BNE not taken after stall: d_btype=010, ops_ready=0 for 3 cycles then 1, cmp_result=0 -> stall_d=1 for exactly 3 cycles; redirect_valid stays 0; br_cnt=1, taken_cnt=0.
- Timeout: MAX_WAIT=4, ops_ready held 0 -> stall_d high 4 cycles; err_timeout=1 on the 5th; state IDLE; counters unchanged; flag persists until reset.
- Flush in WAIT and RESOLVED: d_flush during WAIT -> IDLE with no redirect. Taken branch with d_flush in RESOLVED -> redirect_valid stays 0.
- Back-to-back: taken branch, then branch in delay slot the next cycle -> stall_d=1 in RESOLVED; second branch resolved the following cycle; redirect strobes are separated by one idle cycle.
- Async reset mid-WAIT and saturation: reset pulse between clock edges -> all outputs 0 immediately. With CNT_W=4 and 20 taken branches -> br_cnt=taken_cnt=15.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: holds a D-stage branch until its operands are ready, resolves it and issues a one-cycle PC redirect
// Ports: clk/reset (async, active-high); d_valid, d_btype, d_target, ops_ready, d_flush, cmp_result from D stage;
// cmp_btype to the comparator; stall_d, redirect_valid/redirect_pc to F/D; busy, err_timeout, br_cnt, taken_cnt status.
module branch_resolve_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [2:0]       d_btype,
  input  logic [31:0]      d_target,
  input  logic             ops_ready,
  input  logic             d_flush,
  input  logic             cmp_result,
  output logic [2:0]       cmp_btype,
  output logic             stall_d,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESOLVED = 2'd2;
  logic [1:0] state, state_n;
  logic taken_q;
  logic [31:0] target_q;
  logic [7:0] wait_cnt;
  logic is_br, enter, hold, timeout, resolve;
  assign is_br = d_valid && d_btype != 3'b000;
  assign cmp_btype = is_br ? d_btype : 3'b000;
  assign enter = state == IDLE && is_br && !d_flush && !ops_ready;
  // watchdog is checked before the wait counter would advance again
  assign timeout = state == WAIT && !d_flush && !ops_ready && wait_cnt == 8'(MAX_WAIT);
  assign hold = state == WAIT && !d_flush && !ops_ready && !timeout;
  assign resolve = (state == IDLE && is_br && !d_flush && ops_ready) || (state == WAIT && !d_flush && ops_ready);
  // a branch arriving in the delay slot is held one cycle and re-evaluated from IDLE
  assign stall_d = enter || hold || (state == RESOLVED && is_br);
  assign busy = state != IDLE;
  assign redirect_valid = state == RESOLVED && taken_q && !d_flush;
  assign redirect_pc = (state == RESOLVED && taken_q) ? target_q : 32'd0;
  always_comb state_n = resolve ? RESOLVED : (enter || hold) ? WAIT : IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      taken_q <= 1'b0;
      target_q <= 32'd0;
      wait_cnt <= 8'd0;
      err_timeout <= 1'b0;
      br_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= enter ? 8'd1 : hold ? wait_cnt + 8'd1 : 8'd0;
      if (timeout) err_timeout <= 1'b1;
      if (resolve) begin
        taken_q <= cmp_result;
        target_q <= d_target;
        br_cnt <= br_cnt + CNT_W'(br_cnt != '1);
        taken_cnt <= taken_cnt + CNT_W'(cmp_result && taken_cnt != '1);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: randomized transaction-level scoreboard bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
  localparam int MW = 4;
  localparam int CW = 4;
  localparam int SAT = 15;
  logic clk = 0, reset = 1;
  logic d_valid = 0, ops_ready = 0, d_flush = 0, cmp_result = 0;
  logic [2:0] d_btype = 0;
  logic [31:0] d_target = 0;
  logic [2:0] cmp_btype;
  logic stall_d, redirect_valid, busy, err_timeout;
  logic [31:0] redirect_pc;
  logic [CW-1:0] br_cnt, taken_cnt;
  int checks = 0, passed = 0;
  int stall_seen = 0;
  int br_m = 0, tk_m = 0;
  bit err_m = 0, prev_rv = 0;
  logic [31:0] exp_q[$];

  branch_resolve_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_btype(d_btype), .d_target(d_target),
    .ops_ready(ops_ready), .d_flush(d_flush), .cmp_result(cmp_result), .cmp_btype(cmp_btype),
    .stall_d(stall_d), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
    .err_timeout(err_timeout), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) if (!reset) begin
    if (stall_d) stall_seen++;
    chk("cmp_btype", cmp_btype, (d_valid && d_btype != 0) ? d_btype : 3'd0);
    if (redirect_valid) begin
      chk("redirect_gap", prev_rv, 0);
      chk("redirect_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("redirect_pc", redirect_pc, exp_q.pop_front());
    end
    prev_rv = redirect_valid;
  end

  function automatic int sat_inc(input int v);
    return v < SAT ? v + 1 : v;
  endfunction

  task automatic end_checks(input int stalls);
    chk("stall_cycles", stall_seen, stalls);
    chk("missed_redirect", exp_q.size(), 0);
    chk("br_cnt", br_cnt, br_m);
    chk("taken_cnt", taken_cnt, tk_m);
    chk("err_timeout", err_timeout, err_m);
    chk("busy_idle", busy, 0);
    exp_q.delete();
  endtask

  // one branch: operands become ready after `delay` cycles, optional flush at wait cycle fw, optional flush in the redirect cycle
  task automatic branch(input logic [2:0] bt, input logic [31:0] tg, input bit res, input int delay, input int fw, input bit fr);
    int lim, last, stalls;
    bit resolved;
    lim = delay < MW ? delay : MW;
    if (fw >= 1 && fw <= lim) begin stalls = fw; last = fw; resolved = 0; end
    else if (delay > MW) begin stalls = MW; last = MW; resolved = 0; err_m = 1; end
    else begin stalls = delay; last = delay; resolved = 1; end
    if (resolved) begin
      br_m = sat_inc(br_m);
      if (res) tk_m = sat_inc(tk_m);
      if (res && !fr) exp_q.push_back(tg);
    end
    stall_seen = 0;
    for (int c = 0; c <= last; c++) begin
      d_valid = 1; d_btype = bt; d_target = tg; cmp_result = res;
      ops_ready = c >= delay; d_flush = c == fw;
      @(posedge clk); #1;
    end
    d_valid = 0; d_btype = 3'($urandom); ops_ready = 1'($urandom); cmp_result = 1'($urandom);
    d_target = $urandom; d_flush = resolved && fr;
    @(posedge clk); #1;
    d_flush = 0;
    end_checks(stalls);
  endtask

  initial begin
    #3;
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_br_cnt", br_cnt, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
    chk("rst_stall", stall_d, 0);
    @(posedge clk); #1;
    reset = 0;
    branch(3'b001, 32'h0000_3010, 1, 0, -1, 0);
    branch(3'b010, 32'h0000_4444, 0, 3, -1, 0);
    branch(3'b101, 32'h0000_5550, 1, 10, -1, 0);
    branch(3'b100, 32'h0000_6660, 1, 3, 2, 0);
    branch(3'b001, 32'h0000_7770, 1, 0, -1, 1);
    stall_seen = 0;
    br_m = sat_inc(sat_inc(br_m)); tk_m = sat_inc(sat_inc(tk_m));
    exp_q.push_back(32'h100); exp_q.push_back(32'h200);
    d_valid = 1; d_btype = 3'b001; d_target = 32'h100; cmp_result = 1; ops_ready = 1;
    @(posedge clk); #1;
    d_btype = 3'b011; d_target = 32'h200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d_valid = 0;
    @(posedge clk); #1;
    end_checks(1);
    for (int i = 0; i < 150; i++)
      branch(3'($urandom_range(1, 7)), $urandom, 1'($urandom), $urandom_range(0, 6),
             ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : -1, $urandom_range(0, 4) == 0);
    d_valid = 1; d_btype = 3'b110; ops_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    d_valid = 0; reset = 1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_err", err_timeout, 0);
    chk("async_br_cnt", br_cnt, 0);
    chk("async_taken_cnt", taken_cnt, 0);
    chk("async_redirect_valid", redirect_valid, 0);
    chk("async_redirect_pc", redirect_pc, 0);
    chk("async_stall", stall_d, 0);
    chk("async_cmp_btype", cmp_btype, 0);
    @(posedge clk); #1;
    reset = 0; br_m = 0; tk_m = 0; err_m = 0; prev_rv = 0; exp_q.delete();
    for (int i = 0; i < 20; i++) branch(3'($urandom_range(1, 7)), $urandom, 1, 0, -1, 0);
    chk("sat_br_cnt", br_cnt, 15);
    chk("sat_taken_cnt", taken_cnt, 15);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
